// File: rtl/mips_exec_datapath_pkg.sv
// ---------------------------------------------------------------------------
// mips_exec_pkg
// Shared definitions for the single-cycle MIPS execute slice: opcode and
// funct constants, the ALU operation encoding, the decoded control bundle
// and the default register reset value.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_exec_pkg;

    localparam logic [31:0] DEF_RESET_VAL = 32'd4;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_ADDU = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_SUBU = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_LUI  = 4'd10
    } alu_ctr_t;

    typedef struct packed {
        logic     reg_dst;
        logic     reg_write;
        logic     alu_src;
        logic     sign_ext;
        logic     mem_read;
        logic     mem_write;
        logic     branch;
        logic     jump;
        alu_ctr_t alu_ctr;
    } ctrl_t;

endpackage

// File: rtl/mips_exec_datapath_if.sv
// ---------------------------------------------------------------------------
// mips_exec_datapath_if
// Bus bundle between instruction fetch / next stage (master) and the execute
// slice (slave). There is no handshake: the slice consumes `instr` every
// cycle and every other signal is a plain combinational level.
//   instr, dbg_sel                : master -> slave
//   busA, busB, busW, dbg_data    : slave -> master (data buses)
//   alu_v, alu_cout, alu_zero     : slave -> master (ALU flags)
//   mem_read, mem_write, branch,
//   jump                          : slave -> master (decoded controls)
// ---------------------------------------------------------------------------
interface mips_exec_datapath_if;
    logic [31:0] instr;
    logic [4:0]  dbg_sel;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [31:0] busW;
    logic [31:0] dbg_data;
    logic        alu_v;
    logic        alu_cout;
    logic        alu_zero;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;

    modport master (
        output instr, dbg_sel,
        input  busA, busB, busW, dbg_data,
        input  alu_v, alu_cout, alu_zero,
        input  mem_read, mem_write, branch, jump
    );

    modport slave (
        input  instr, dbg_sel,
        output busA, busB, busW, dbg_data,
        output alu_v, alu_cout, alu_zero,
        output mem_read, mem_write, branch, jump
    );
endinterface

// File: rtl/mips_exec_datapath_decoder.sv
// ---------------------------------------------------------------------------
// exec_ctrl_decoder
// Purely combinational instruction decoder.
//   instr  in  32  instruction word
//   ctrl   out     decoded control bundle (ctrl_t), incl. alu_ctr
//   rs     out 5   instr[25:21]
//   rt     out 5   instr[20:16]
//   rd     out 5   instr[15:11]
//   imm16  out 16  instr[15:0]
// Unknown opcodes and unknown R-type functs decode to all-zero controls with
// ALU op ADD, so nothing is written and no side-effect signal is raised.
// ---------------------------------------------------------------------------
module exec_ctrl_decoder
    import mips_exec_pkg::*;
(
    input  logic [31:0] instr,
    output ctrl_t       ctrl,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [15:0] imm16
);

    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_shamt;

    assign op           = instr[31:26];
    assign funct        = instr[5:0];
    assign rs           = instr[25:21];
    assign rt           = instr[20:16];
    assign rd           = instr[15:11];
    assign imm16        = instr[15:0];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        ctrl         = '0;
        ctrl.alu_ctr = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                // Controls are raised only for a recognised funct.
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD:  ctrl.alu_ctr = ALU_ADD;
                    FN_ADDU: ctrl.alu_ctr = ALU_ADDU;
                    FN_SUB:  ctrl.alu_ctr = ALU_SUB;
                    FN_SUBU: ctrl.alu_ctr = ALU_SUBU;
                    FN_AND:  ctrl.alu_ctr = ALU_AND;
                    FN_OR:   ctrl.alu_ctr = ALU_OR;
                    FN_XOR:  ctrl.alu_ctr = ALU_XOR;
                    FN_NOR:  ctrl.alu_ctr = ALU_NOR;
                    FN_SLT:  ctrl.alu_ctr = ALU_SLT;
                    FN_SLTU: ctrl.alu_ctr = ALU_SLTU;
                    default: begin
                        ctrl         = '0;
                        ctrl.alu_ctr = ALU_ADD;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.sign_ext  = 1'b1;
                case (op)
                    OP_ADDI:  ctrl.alu_ctr = ALU_ADD;
                    OP_ADDIU: ctrl.alu_ctr = ALU_ADDU;
                    OP_SLTI:  ctrl.alu_ctr = ALU_SLT;
                    default:  ctrl.alu_ctr = ALU_SLTU;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                case (op)
                    OP_ANDI: ctrl.alu_ctr = ALU_AND;
                    OP_ORI:  ctrl.alu_ctr = ALU_OR;
                    OP_XORI: ctrl.alu_ctr = ALU_XOR;
                    default: ctrl.alu_ctr = ALU_LUI;
                endcase
            end
            OP_LW: begin
                // Writes the effective address until a memory stage exists.
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.sign_ext  = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.sign_ext  = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.sign_ext = 1'b1;
                ctrl.branch   = 1'b1;
                ctrl.alu_ctr  = ALU_SUB;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: begin
                ctrl         = '0;
                ctrl.alu_ctr = ALU_ADD;
            end
        endcase
    end

endmodule

// File: rtl/mips_exec_datapath.sv
// ---------------------------------------------------------------------------
// mips_exec_datapath
// Single-cycle MIPS execute slice: decoder, 32x32 register file (2 async
// reads, 1 sync write), immediate extender and ALU. The ALU result is the
// write-back data.
//   CLK  in   clock, all state updates on rising edge
//   rst  in   synchronous active-high reset, loads RESET_VAL in every register
//   bus  slave modport of mips_exec_datapath_if (instr/dbg_sel in; buses,
//        flags and decoded controls out, all combinational)
// Register $0 is an ordinary writable register.
// ---------------------------------------------------------------------------
module mips_exec_datapath
    import mips_exec_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = DEF_RESET_VAL
) (
    input  logic                  CLK,
    input  logic                  rst,
    mips_exec_datapath_if.slave   bus
);

    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  rw;
    logic [15:0] imm16;
    logic [31:0] imm32;
    logic [31:0] regs [32];
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_b;
    logic [31:0] b_eff;
    logic [32:0] sum;
    logic        sub_op;
    logic [31:0] result;
    logic        ovf;

    exec_ctrl_decoder u_decoder (
        .instr (bus.instr),
        .ctrl  (ctrl),
        .rs    (rs),
        .rt    (rt),
        .rd    (rd),
        .imm16 (imm16)
    );

    // Register file: reads see the pre-edge contents during a write cycle.
    always_ff @(posedge CLK) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (ctrl.reg_write) begin
            regs[rw] <= result;
        end
    end

    assign rw    = ctrl.reg_dst ? rd : rt;
    assign a     = regs[rs];
    assign b     = regs[rt];
    assign imm32 = ctrl.sign_ext ? {{16{imm16[15]}}, imm16} : {16'd0, imm16};
    assign alu_b = ctrl.alu_src ? imm32 : b;

    // Subtract-class ops (including the compares) share one A + ~B + 1 adder.
    always_comb begin
        sub_op = (ctrl.alu_ctr == ALU_SUB)  || (ctrl.alu_ctr == ALU_SUBU) ||
                 (ctrl.alu_ctr == ALU_SLT)  || (ctrl.alu_ctr == ALU_SLTU);
        b_eff  = sub_op ? ~alu_b : alu_b;
        sum    = {1'b0, a} + {1'b0, b_eff} + {32'd0, sub_op};
        // Signed overflow: operands of equal sign produce a result of the
        // other sign (B already inverted for subtraction).
        ovf    = (a[31] == b_eff[31]) && (sum[31] != a[31]);

        result = sum[31:0];
        case (ctrl.alu_ctr)
            ALU_ADD, ALU_ADDU, ALU_SUB, ALU_SUBU: result = sum[31:0];
            ALU_AND:  result = a & alu_b;
            ALU_OR:   result = a | alu_b;
            ALU_XOR:  result = a ^ alu_b;
            ALU_NOR:  result = ~(a | alu_b);
            ALU_SLT:  result = {31'd0, $signed(a) < $signed(alu_b)};
            ALU_SLTU: result = {31'd0, a < alu_b};
            ALU_LUI:  result = {alu_b[15:0], 16'd0};
            default:  result = sum[31:0];
        endcase
    end

    assign bus.busA      = a;
    assign bus.busB      = b;
    assign bus.busW      = result;
    assign bus.alu_cout  = sum[32];
    assign bus.alu_v     = ((ctrl.alu_ctr == ALU_ADD) || (ctrl.alu_ctr == ALU_SUB)) ? ovf : 1'b0;
    assign bus.alu_zero  = (result == 32'd0);
    assign bus.mem_read  = ctrl.mem_read;
    assign bus.mem_write = ctrl.mem_write;
    assign bus.branch    = ctrl.branch;
    assign bus.jump      = ctrl.jump;
    assign bus.dbg_data  = regs[bus.dbg_sel];

endmodule

// File: tb/tb_mips_exec_datapath.sv
// ---------------------------------------------------------------------------
// tb_mips_exec_datapath
// Directed vectors with hand-computed expected values. Inputs change 1 time
// unit after the rising edge; outputs are sampled mid-cycle. A small register
// model tracks the architectural state for the full register sweeps.
// ---------------------------------------------------------------------------
module tb_mips_exec_datapath;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] model_regs [32];

    mips_exec_datapath_if bus ();

    mips_exec_datapath #(.RESET_VAL(32'd4)) dut (
        .CLK (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present an instruction and let the combinational outputs settle.
    task automatic apply(input logic [31:0] ins);
        bus.instr = ins;
        #3;
    endtask

    // Take the rising edge, then park on an illegal op so nothing else writes.
    task automatic commit();
        @(posedge clk);
        #1;
        bus.instr = 32'hFC000000;
    endtask

    task automatic check_reg(input string tag, input int idx);
        bus.dbg_sel = idx[4:0];
        #1;
        check(tag, bus.dbg_data, model_regs[idx]);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 32; i++) begin
            check_reg($sformatf("%s_r%0d", tag, i), i);
        end
    endtask

    task automatic check_ctrl(input string tag, input logic [3:0] exp);
        check({tag, "_ctrl"}, {28'd0, bus.mem_read, bus.mem_write, bus.branch, bus.jump}, {28'd0, exp});
    endtask

    initial begin
        rst         = 1'b1;
        bus.instr   = 32'hFC000000;
        bus.dbg_sel = 5'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd4;
        check_all_regs("reset");

        // add $3,$1,$2
        apply(32'h00221820);
        check("add_busA", bus.busA, 32'd4);
        check("add_busB", bus.busB, 32'd4);
        check("add_busW", bus.busW, 32'd8);
        check("add_v", {31'd0, bus.alu_v}, 32'd0);
        check_ctrl("add", 4'b0000);
        commit();
        model_regs[3] = 32'd8;
        check_reg("add_r3", 3);

        // addi $5,$0,-1 : 4 + 0xFFFFFFFF wraps with carry, no overflow
        apply(32'h2005FFFF);
        check("addi_busW", bus.busW, 32'd3);
        check("addi_v", {31'd0, bus.alu_v}, 32'd0);
        check("addi_cout", {31'd0, bus.alu_cout}, 32'd1);
        commit();
        model_regs[5] = 32'd3;
        check_reg("addi_r5", 5);

        // addi $5,$5,1 : source is the target, old value read before the edge
        apply(32'h20A50001);
        check("rdwr_busA", bus.busA, 32'd3);
        check("rdwr_busW", bus.busW, 32'd4);
        commit();
        model_regs[5] = 32'd4;
        check_reg("rdwr_r5", 5);

        // ori $6,$0,0x8000 : zero-extended immediate
        apply(32'h34068000);
        check("ori_busW", bus.busW, 32'h00008004);
        commit();
        model_regs[6] = 32'h00008004;
        check_reg("ori_r6", 6);

        // lui $7,0x8000
        apply(32'h3C078000);
        check("lui_busW", bus.busW, 32'h80000000);
        commit();
        model_regs[7] = 32'h80000000;
        check_reg("lui_r7", 7);

        // sub $8,$7,$1 : 0x80000000 - 4 overflows
        apply(32'h00E14022);
        check("sub_busA", bus.busA, 32'h80000000);
        check("sub_busW", bus.busW, 32'h7FFFFFFC);
        check("sub_v", {31'd0, bus.alu_v}, 32'd1);
        check("sub_cout", {31'd0, bus.alu_cout}, 32'd1);
        commit();
        model_regs[8] = 32'h7FFFFFFC;
        check_reg("sub_r8", 8);

        // subu $13,$7,$1 : same arithmetic, overflow flag suppressed
        apply(32'h00E16823);
        check("subu_busW", bus.busW, 32'h7FFFFFFC);
        check("subu_v", {31'd0, bus.alu_v}, 32'd0);
        commit();
        model_regs[13] = 32'h7FFFFFFC;

        // addi $12,$7,-1 : signed add overflow
        apply(32'h20ECFFFF);
        check("addiv_busW", bus.busW, 32'h7FFFFFFF);
        check("addiv_v", {31'd0, bus.alu_v}, 32'd1);
        commit();
        model_regs[12] = 32'h7FFFFFFF;

        // nor $14,$0,$0
        apply(32'h00007027);
        check("nor_busW", bus.busW, 32'hFFFFFFFB);
        commit();
        model_regs[14] = 32'hFFFFFFFB;

        // beq $1,$2 : branch raised, equal operands give zero, no write
        apply(32'h10220003);
        check_ctrl("beq", 4'b0010);
        check("beq_zero", {31'd0, bus.alu_zero}, 32'd1);
        commit();
        check_all_regs("beq");

        // sw $1,0($0) : address 4, no write
        apply(32'hAC010000);
        check_ctrl("sw", 4'b0100);
        check("sw_busW", bus.busW, 32'd4);
        commit();
        check_all_regs("sw");

        // lw $11,16($0) : effective address is written back
        apply(32'h8C0B0010);
        check_ctrl("lw", 4'b1000);
        check("lw_busW", bus.busW, 32'h14);
        commit();
        model_regs[11] = 32'h14;
        check_reg("lw_r11", 11);

        // j
        apply(32'h08000010);
        check_ctrl("j", 4'b0001);
        commit();
        check_all_regs("j");

        // illegal opcode and illegal funct: no controls, no write
        apply(32'hFC000000);
        check_ctrl("illop", 4'b0000);
        commit();
        apply(32'h0022183F);
        check_ctrl("illfn", 4'b0000);
        check("illfn_busW", bus.busW, 32'd8);
        commit();
        check_all_regs("illegal");

        // slt $9,$7,$1 : 0x80000000 < 4 signed
        apply(32'h00E1482A);
        check("slt_busW", bus.busW, 32'd1);
        check("slt_zero", {31'd0, bus.alu_zero}, 32'd0);
        commit();
        model_regs[9] = 32'd1;
        check_reg("slt_r9", 9);

        // sltu $10,$7,$1 : 0x80000000 < 4 unsigned is false
        apply(32'h00E1502B);
        check("sltu_busW", bus.busW, 32'd0);
        check("sltu_zero", {31'd0, bus.alu_zero}, 32'd1);
        commit();
        model_regs[10] = 32'd0;
        check_reg("sltu_r10", 10);

        // addi $0,$0,1 : $0 is writable
        apply(32'h20000001);
        check("r0_busW", bus.busW, 32'd5);
        commit();
        model_regs[0] = 32'd5;
        check_reg("r0_write", 0);

        // reset while a writing instruction (addi $9,$0,7) is presented
        apply(32'h20090007);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.instr = 32'hFC000000;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd4;
        check_all_regs("rst2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
